// File: rtl/frontend_pipe_regs.sv
// Fetch PC, IF/ID and ID/EX registers of the 5-stage core, applying hazard-unit
// stall/flush/redirect requests each edge, plus stall/flush event counters.
module frontend_pipe_regs #(
    parameter int               XLEN     = 32,
    parameter int               CTRL_W   = 12,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              StallF,
    input  logic              StallD,
    input  logic              FlushD,
    input  logic              FlushE,
    input  logic              PCSrcE,
    input  logic [XLEN-1:0]   PCTargetE,
    input  logic [31:0]       InstrF,
    output logic [XLEN-1:0]   PCF,
    output logic [31:0]       InstrD,
    output logic [XLEN-1:0]   PCD,
    output logic [XLEN-1:0]   PCPlus4D,
    output logic              ValidD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    input  logic [CTRL_W-1:0] CtrlD,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic [CTRL_W-1:0] CtrlE,
    output logic              ValidE,
    output logic [31:0]       StallCount,
    output logic [31:0]       FlushCount
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
        logic            valid;
    } ifIdT;

    typedef struct packed {
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   immExt;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pcPlus4;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [CTRL_W-1:0] ctrl;
        logic              valid;
    } idExT;

    logic [XLEN-1:0] pcQ;
    logic [XLEN-1:0] pcPlus4F;
    ifIdT            ifIdQ;
    idExT            idExQ;
    logic [31:0]     stallCnt;
    logic [31:0]     flushCnt;

    assign pcPlus4F = pcQ + XLEN'(4);

    // Redirect takes priority over a fetch stall.
    always_ff @(posedge clk) begin
        if (reset)        pcQ <= RESET_PC;
        else if (PCSrcE)  pcQ <= PCTargetE;
        else if (!StallF) pcQ <= pcPlus4F;
    end

    // Flush beats stall: a squashed slot must not survive a held stage.
    always_ff @(posedge clk) begin
        if (reset || FlushD) begin
            ifIdQ <= '{instr: NOP, pc: '0, pcPlus4: '0, valid: 1'b0};
        end else if (!StallD) begin
            ifIdQ <= '{instr: InstrF, pc: pcQ, pcPlus4: pcPlus4F, valid: 1'b1};
        end
    end

    // No stall here; a held decode slot reaches EX as a bubble via FlushE.
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            idExQ <= '0;
        end else begin
            idExQ <= '{rd1: RD1D, rd2: RD2D, immExt: ImmExtD, pc: ifIdQ.pc,
                       pcPlus4: ifIdQ.pcPlus4, rs1: Rs1D, rs2: Rs2D, rd: RdD,
                       ctrl: CtrlD, valid: ifIdQ.valid};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCnt <= '0;
            flushCnt <= '0;
        end else begin
            if (StallF) stallCnt <= stallCnt + 32'd1;
            if (FlushE) flushCnt <= flushCnt + 32'd1;
        end
    end

    assign PCF        = pcQ;
    assign InstrD     = ifIdQ.instr;
    assign PCD        = ifIdQ.pc;
    assign PCPlus4D   = ifIdQ.pcPlus4;
    assign ValidD     = ifIdQ.valid;
    assign RD1E       = idExQ.rd1;
    assign RD2E       = idExQ.rd2;
    assign ImmExtE    = idExQ.immExt;
    assign PCE        = idExQ.pc;
    assign PCPlus4E   = idExQ.pcPlus4;
    assign Rs1E       = idExQ.rs1;
    assign Rs2E       = idExQ.rs2;
    assign RdE        = idExQ.rd;
    assign CtrlE      = idExQ.ctrl;
    assign ValidE     = idExQ.valid;
    assign StallCount = stallCnt;
    assign FlushCount = flushCnt;

endmodule

// File: tb/tb_frontend_pipe_regs.sv
// Directed bench for frontend_pipe_regs: free run, load-use stall, branch
// redirect, redirect-vs-stall priority, PC and counter wrap, reset during stall.
module tb_frontend_pipe_regs;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic              StallF, StallD, FlushD, FlushE, PCSrcE;
    logic [XLEN-1:0]   PCTargetE;
    logic [31:0]       InstrF;
    logic [XLEN-1:0]   PCF;
    logic [31:0]       InstrD;
    logic [XLEN-1:0]   PCD, PCPlus4D;
    logic              ValidD;
    logic [XLEN-1:0]   RD1D, RD2D, ImmExtD;
    logic [4:0]        Rs1D, Rs2D, RdD;
    logic [CTRL_W-1:0] CtrlD;
    logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]        Rs1E, Rs2E, RdE;
    logic [CTRL_W-1:0] CtrlE;
    logic              ValidE;
    logic [31:0]       StallCount, FlushCount;

    int total = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Instruction memory stand-in: word depends on the fetch address.
    function automatic logic [31:0] instrAt(input logic [31:0] pc);
        return 32'hA000_0000 ^ pc;
    endfunction

    assign InstrF = instrAt(PCF);

    frontend_pipe_regs #(.XLEN(XLEN), .CTRL_W(CTRL_W), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
        .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .CtrlD(CtrlD),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .CtrlE(CtrlE), .ValidE(ValidE),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ctrlIdle();
        StallF = 0; StallD = 0; FlushD = 0; FlushE = 0; PCSrcE = 0; PCTargetE = '0;
    endtask

    initial begin
        reset = 1'b1;
        ctrlIdle();
        RD1D = 32'h1111_0001; RD2D = 32'h2222_0002; ImmExtD = 32'h0000_0ABC;
        Rs1D = 5'd1; Rs2D = 5'd2; RdD = 5'd3; CtrlD = 12'h5A5;

        step();
        chk("rst_pcf",    PCF, 32'h0);
        chk("rst_instrd", InstrD, 32'h13);
        chk("rst_pcd",    PCD, 32'h0);
        chk("rst_validd", 32'(ValidD), 32'h0);
        chk("rst_valide", 32'(ValidE), 32'h0);
        chk("rst_ctrle",  32'(CtrlE), 32'h0);
        chk("rst_stall",  StallCount, 32'h0);
        chk("rst_flush",  FlushCount, 32'h0);

        reset = 1'b0;
        step();  // edge 1
        chk("c1_pcf",      PCF, 32'h4);
        chk("c1_instrd",   InstrD, instrAt(32'h0));
        chk("c1_pcplus4d", PCPlus4D, 32'h4);
        chk("c1_validd",   32'(ValidD), 32'h1);
        chk("c1_valide",   32'(ValidE), 32'h0);

        step();  // edge 2
        chk("c2_pcf",    PCF, 32'h8);
        chk("c2_instrd", InstrD, instrAt(32'h4));
        chk("c2_valide", 32'(ValidE), 32'h1);
        chk("c2_pce",    PCE, 32'h0);
        chk("c2_pcp4e",  PCPlus4E, 32'h4);
        chk("c2_rd1e",   RD1E, 32'h1111_0001);
        chk("c2_ctrle",  32'(CtrlE), 32'h5A5);
        chk("c2_rde",    32'(RdE), 32'd3);

        // load-use stall at PCF=8
        StallF = 1; StallD = 1; FlushE = 1;
        step();  // edge 3
        chk("lu_pcf",    PCF, 32'h8);
        chk("lu_instrd", InstrD, instrAt(32'h4));
        chk("lu_pcd",    PCD, 32'h4);
        chk("lu_valide", 32'(ValidE), 32'h0);
        chk("lu_ctrle",  32'(CtrlE), 32'h0);
        chk("lu_rd1e",   RD1E, 32'h0);
        chk("lu_stall",  StallCount, 32'd1);
        chk("lu_flush",  FlushCount, 32'd1);

        ctrlIdle();
        RD1D = 32'h3333_0003;
        step();  // edge 4: held instruction at PC 4 reaches EX
        chk("lu2_pcf",    PCF, 32'hC);
        chk("lu2_instrd", InstrD, instrAt(32'h8));
        chk("lu2_pce",    PCE, 32'h4);
        chk("lu2_valide", 32'(ValidE), 32'h1);
        chk("lu2_rd1e",   RD1E, 32'h3333_0003);

        // taken branch
        PCSrcE = 1; PCTargetE = 32'h100; FlushD = 1; FlushE = 1;
        step();  // edge 5
        chk("br_pcf",    PCF, 32'h100);
        chk("br_instrd", InstrD, 32'h13);
        chk("br_validd", 32'(ValidD), 32'h0);
        chk("br_valide", 32'(ValidE), 32'h0);
        chk("br_flush",  FlushCount, 32'd2);
        chk("br_stall",  StallCount, 32'd1);

        ctrlIdle();
        step();  // edge 6
        chk("br2_pcf",    PCF, 32'h104);
        chk("br2_instrd", InstrD, instrAt(32'h100));
        chk("br2_pcd",    PCD, 32'h100);
        chk("br2_validd", 32'(ValidD), 32'h1);

        // redirect beats fetch stall, flush beats decode stall
        StallF = 1; PCSrcE = 1; PCTargetE = 32'h200; StallD = 1; FlushD = 1;
        step();  // edge 7
        chk("pri_pcf",    PCF, 32'h200);
        chk("pri_instrd", InstrD, 32'h13);
        chk("pri_validd", 32'(ValidD), 32'h0);
        chk("pri_pce",    PCE, 32'h100);
        chk("pri_valide", 32'(ValidE), 32'h1);
        chk("pri_stall",  StallCount, 32'd2);

        // PC wrap
        ctrlIdle();
        PCSrcE = 1; PCTargetE = 32'hFFFF_FFFC;
        step();  // edge 8
        chk("wr_pcf_top", PCF, 32'hFFFF_FFFC);
        ctrlIdle();
        step();  // edge 9
        chk("wr_pcf",      PCF, 32'h0);
        chk("wr_pcd",      PCD, 32'hFFFF_FFFC);
        chk("wr_pcplus4d", PCPlus4D, 32'h0);

        // counter wrap: preload both counters away from the clock edge
        @(negedge clk);
        force dut.stallCnt = 32'hFFFF_FFFF;
        force dut.flushCnt = 32'hFFFF_FFFF;
        #1;
        release dut.stallCnt;
        release dut.flushCnt;
        #1;
        chk("cw_pre_stall", StallCount, 32'hFFFF_FFFF);
        StallF = 1; FlushE = 1;
        step();  // edge 10
        chk("cw_stall", StallCount, 32'h0);
        chk("cw_flush", FlushCount, 32'h0);
        chk("cw_pcf",   PCF, 32'h0);
        step();  // edge 11
        chk("cw1_stall", StallCount, 32'd1);
        chk("cw1_flush", FlushCount, 32'd1);

        // reset during a stall overrides everything, including a redirect
        FlushE = 0; PCSrcE = 1; PCTargetE = 32'h300;
        reset = 1;
        step();  // edge 12
        chk("rs_pcf",    PCF, 32'h0);
        chk("rs_instrd", InstrD, 32'h13);
        chk("rs_validd", 32'(ValidD), 32'h0);
        chk("rs_valide", 32'(ValidE), 32'h0);
        chk("rs_rd1e",   RD1E, 32'h0);
        chk("rs_stall",  StallCount, 32'h0);
        chk("rs_flush",  FlushCount, 32'h0);

        reset = 0;
        ctrlIdle();
        step();  // edge 13: first fetch after reset lands in D
        chk("pr_instrd", InstrD, instrAt(32'h0));
        chk("pr_validd", 32'(ValidD), 32'h1);
        chk("pr_pcf",    PCF, 32'h4);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule

// File: doc/frontend_pipe_regs.md
# frontend_pipe_regs

Stage-boundary register bank that executes the stall and flush requests issued by the pipeline hazard unit. It holds the fetch PC, the IF/ID register and the ID/EX register of the 5-stage RISC-V core. It applies StallF/StallD/FlushD/FlushE and branch redirection on every clock edge, inserting bubbles where requested. It also keeps stall and flush performance counters.

## Interface
Parameters:
- XLEN, 32, datapath width
- CTRL_W, 12, width of the decoded control bundle carried ID→EX
- RESET_PC, 32'h0000_0000, fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- StallF  in  1  hold PCF
- StallD  in  1  hold IF/ID
- FlushD  in  1  clear IF/ID to bubble
- FlushE  in  1  clear ID/EX to bubble
- PCSrcE  in  1  branch/jump taken in EX
- PCTargetE  in  XLEN  redirect target
- InstrF  in  32  instruction read at PCF (combinational imem)
- PCF  out  XLEN  current fetch address
- InstrD, PCD, PCPlus4D  out  32/XLEN/XLEN  IF/ID contents
- ValidD  out  1  IF/ID holds a real instruction
- RD1D, RD2D, ImmExtD  in  XLEN  decode-stage operands
- Rs1D, Rs2D, RdD  in  5  decode-stage register indices
- CtrlD  in  CTRL_W  decode-stage control bundle
- RD1E, RD2E, ImmExtE, PCE, PCPlus4E  out  XLEN  ID/EX contents
- Rs1E, Rs2E, RdE  out  5  ID/EX register indices
- CtrlE  out  CTRL_W  ID/EX control bundle
- ValidE  out  1  ID/EX holds a real instruction
- StallCount  out  32  cycles with StallF=1
- FlushCount  out  32  cycles with FlushE=1

## Operation
- PCPlus4F = PCF + 4, modulo 2^XLEN (combinational, internal).
- PC next: reset → RESET_PC; else PCSrcE → PCTargetE; else StallF → hold; else PCPlus4F. A redirect overrides StallF.
- IF/ID next: reset or FlushD → InstrD=32'h0000_0013 (NOP), PCD=0, PCPlus4D=0, ValidD=0. Else StallD → hold. Else capture InstrF, PCF, PCPlus4F and set ValidD=1. FlushD overrides StallD.
- ID/EX next: reset or FlushE → all data/index fields 0, CtrlE=0, ValidE=0. Else capture the D-side inputs, PCD and PCPlus4D, and ValidE=ValidD. The ID/EX register has no stall input, so a load-use stall becomes a bubble through FlushE.
- CtrlE=0 must encode "no RegWrite, no MemWrite, no branch/jump". Decode owns this encoding.
- Counters: reset → 0. StallCount += 1 on each edge where StallF=1. FlushCount += 1 on each edge where FlushE=1. Both wrap 2^32−1 → 0. Both hold during reset.
- PCSrcE is honoured regardless of ValidE. The hazard unit asserts FlushD/FlushE on the same cycle, so the squash is its responsibility.

## Timing
- All state updates on rising clk. Outputs are registered, except that PCF is itself a register output.
- Reset values: PCF=RESET_PC, InstrD=NOP, PCD=PCPlus4D=0, ValidD=0, all E outputs 0, ValidE=0, StallCount=FlushCount=0.
- Fetch→D latency 1 cycle; D→E latency 1 cycle; redirect latency 1 cycle (PCF=PCTargetE on the edge after PCSrcE=1).
- Reset asserted mid-operation overrides every control input on that edge. The first real fetch is captured into D on the first edge after reset deasserts.
- Load-use stall (StallF=StallD=FlushE=1 for one cycle):
  - PCF and IF/ID hold.
  - ID/EX becomes a bubble.
  - The next cycle re-presents the same D instruction to EX.
- Taken branch (PCSrcE=FlushD=FlushE=1):
  - PCF loads the target.
  - Both D and E become bubbles on the same edge.

## Test plan
- Reset then 3 free-running cycles with InstrF=PCF-dependent pattern → PCF 0,4,8,12. InstrD lags by 1 cycle and ValidD goes 1 at cycle 1. ValidE goes 1 at cycle 2.
- Load-use stall at PCF=8 (StallF=StallD=FlushE=1, one cycle) → PCF stays 8, InstrD unchanged, ValidE=0, CtrlE=0, StallCount=1, FlushCount=1. The next cycle, E receives the held D instruction.
- Taken branch PCSrcE=1, PCTargetE=32'h100 with FlushD=FlushE=1 → next PCF=32'h100, InstrD=32'h13, ValidD=0, ValidE=0. The cycle after, InstrD=InstrF@0x100.
- Simultaneous StallF=1 and PCSrcE=1, with StallD=1 and FlushD=1 → PCF=PCTargetE (redirect wins) and IF/ID becomes a bubble (flush wins).
- PC wrap: force PCF=32'hFFFF_FFFC and run free → PCF=0. Preload the counters to 32'hFFFF_FFFF and assert StallF and FlushE → both counters read 0.
- Reset asserted during a stall (StallF=1) → on that edge all outputs take their reset values and the counters do not increment.
